// File: rtl/regfile_sched_pkg.sv
// Shared widths and ecall sequencing states for the writeback scheduler.
package regfile_sched_pkg;

  localparam int XLEN  = 64;
  localparam int NREGS = 32;
  localparam int RW    = $clog2(NREGS);

  typedef enum logic [1:0] {
    ES_IDLE,
    ES_DRAIN,
    ES_CALL,
    ES_RELEASE
  } ecall_sched_state_t;

endpackage

// File: rtl/regfile_wb_scheduler_rr_arbiter.sv
// Round-robin arbiter: the search starts at the pointer, and the pointer moves
// to just past the winner whenever a grant is issued.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_reg;
  logic [PW-1:0] ptr_next;
  logic [PW-1:0] winner;
  logic          found;
  int            idx;

  // Pick the first requester at or after the pointer; grant only when allowed.
  always_comb begin
    gnt      = '0;
    winner   = ptr_reg;
    found    = 1'b0;
    idx      = 0;
    ptr_next = ptr_reg;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_reg) + k) % N;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = PW'(idx);
      end
    end
    if (advance && found) begin
      gnt[winner] = 1'b1;
      ptr_next    = (int'(winner) == N - 1) ? '0 : winner + PW'(1);
    end
  end

  // Pointer register; returns to producer 0 on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_reg <= '0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Register-file write-port owner: arbitrates writeback producers, keeps the
// destination busy scoreboard for decode, and sequences the ecall handshake.
module regfile_wb_scheduler #(
  parameter int NUM_SRC = 3,
  parameter int XLEN    = 64,
  parameter int NREGS   = 32,
  localparam int RW     = $clog2(NREGS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    issue_valid,
  input  logic [RW-1:0]           issue_rd,
  output logic                    issue_ready,
  input  logic [RW-1:0]           chk_rs1,
  input  logic [RW-1:0]           chk_rs2,
  output logic                    hazard,
  input  logic [NUM_SRC-1:0]      src_valid,
  input  logic [NUM_SRC*RW-1:0]   src_rd,
  input  logic [NUM_SRC*XLEN-1:0] src_data,
  output logic [NUM_SRC-1:0]      src_ready,
  output logic                    write_enable,
  output logic [RW-1:0]           write_register,
  output logic [XLEN-1:0]         write_value,
  input  logic                    ecall_req,
  output logic                    ecall,
  input  logic                    ecall_done,
  output logic                    ecall_ack
);

  import regfile_sched_pkg::*;

  ecall_sched_state_t state_reg, state_next;

  logic [NUM_SRC-1:0] gnt;
  logic               grant_allowed;
  logic               xfer;
  logic [RW-1:0]      win_rd;
  logic [XLEN-1:0]    win_data;

  logic               we_reg;
  logic [RW-1:0]      wr_reg;
  logic [XLEN-1:0]    wv_reg;
  logic               ecall_reg;
  logic               ack_reg;

  logic [NREGS-1:0]   busy_reg;
  logic [NREGS-1:0]   busy_next;
  logic [NREGS-1:0]   set_hit;
  logic [NREGS-1:0]   clr_hit;
  logic               issue_fire;
  logic               drained;

  assign grant_allowed = (state_reg != ES_CALL);

  rr_arbiter #(.N(NUM_SRC)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (src_valid),
    .advance (grant_allowed),
    .gnt     (gnt)
  );

  assign src_ready = gnt;
  assign xfer      = |gnt;

  // One-hot select of the granted producer's destination and data.
  always_comb begin
    win_rd   = '0;
    win_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (gnt[i]) begin
        win_rd   = win_rd | src_rd[i*RW +: RW];
        win_data = win_data | src_data[i*XLEN +: XLEN];
      end
    end
  end

  // Write port registers; x0 transfers are consumed without strobing the file.
  always_ff @(posedge clk) begin
    if (reset) begin
      we_reg <= 1'b0;
      wr_reg <= '0;
      wv_reg <= '0;
    end else begin
      we_reg <= xfer && (win_rd != '0);
      if (xfer) begin
        wr_reg <= win_rd;
        wv_reg <= win_data;
      end
    end
  end

  assign write_enable   = we_reg;
  assign write_register = wr_reg;
  assign write_value    = wv_reg;

  // A register retiring this cycle is not a WAW hazard for a new issue.
  assign issue_ready = (state_reg == ES_IDLE) &&
                       (!busy_reg[issue_rd] || (we_reg && (wr_reg == issue_rd)));
  assign issue_fire  = issue_valid && issue_ready && (issue_rd != '0);

  // Sources are pending unless x0 or being written (the file forwards write_value).
  function automatic logic rs_pending(input logic [RW-1:0] rs,
                                      input logic [NREGS-1:0] busy,
                                      input logic we, input logic [RW-1:0] wr);
    return (rs != '0) && busy[rs] && !(we && (wr == rs));
  endfunction

  assign hazard = rs_pending(chk_rs1, busy_reg, we_reg, wr_reg) ||
                  rs_pending(chk_rs2, busy_reg, we_reg, wr_reg);

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_sb
      assign set_hit[gi]   = issue_fire && (issue_rd == RW'(gi));
      assign clr_hit[gi]   = we_reg && (wr_reg == RW'(gi));
      // Set wins over clear when a retiring register is reissued.
      assign busy_next[gi] = set_hit[gi] | (busy_reg[gi] & ~clr_hit[gi]);
    end
  endgenerate

  // Busy scoreboard register.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  assign drained = (busy_reg == '0) && !we_reg && (src_valid == '0);

  // Ecall sequencing: drain, hold ecall until done, then a one-cycle ack.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ES_IDLE:    if (ecall_req) state_next = ES_DRAIN;
      ES_DRAIN: begin
        if (!ecall_req)   state_next = ES_IDLE;
        else if (drained) state_next = ES_CALL;
      end
      ES_CALL:    if (ecall_done) state_next = ES_RELEASE;
      ES_RELEASE: state_next = ES_IDLE;
      default:    state_next = ES_IDLE;
    endcase
  end

  // State plus registered ecall/ack decoded from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ES_IDLE;
      ecall_reg <= 1'b0;
      ack_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      ecall_reg <= (state_next == ES_CALL);
      ack_reg   <= (state_next == ES_RELEASE);
    end
  end

  assign ecall     = ecall_reg;
  assign ecall_ack = ack_reg;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for the writeback scheduler: arbitration order, scoreboard,
// x0 handling, ecall drain/call/release and reset abandonment.
module tb_regfile_wb_scheduler;

  localparam int NS = 3;
  localparam int XL = 64;
  localparam int RW = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             issue_valid;
  logic [RW-1:0]    issue_rd;
  logic             issue_ready;
  logic [RW-1:0]    chk_rs1, chk_rs2;
  logic             hazard;
  logic [NS-1:0]    src_valid;
  logic [NS*RW-1:0] src_rd;
  logic [NS*XL-1:0] src_data;
  logic [NS-1:0]    src_ready;
  logic             write_enable;
  logic [RW-1:0]    write_register;
  logic [XL-1:0]    write_value;
  logic             ecall_req, ecall, ecall_done, ecall_ack;

  int errors = 0;
  int checks = 0;

  regfile_wb_scheduler #(.NUM_SRC(NS), .XLEN(XL), .NREGS(32)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .hazard(hazard),
    .src_valid(src_valid), .src_rd(src_rd), .src_data(src_data), .src_ready(src_ready),
    .write_enable(write_enable), .write_register(write_register), .write_value(write_value),
    .ecall_req(ecall_req), .ecall(ecall), .ecall_done(ecall_done), .ecall_ack(ecall_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_src(input int i, input logic v, input logic [RW-1:0] rd,
                         input logic [XL-1:0] d);
    src_valid[i]       = v;
    src_rd[i*RW +: RW] = rd;
    src_data[i*XL +: XL] = d;
  endtask

  logic [NS-1:0]  exp_gnt  [4];
  logic [RW-1:0]  exp_rd   [4];
  logic [XL-1:0]  exp_data [4];

  initial begin
    reset = 1'b1; issue_valid = 1'b0; issue_rd = '0; chk_rs1 = '0; chk_rs2 = '0;
    src_valid = '0; src_rd = '0; src_data = '0;
    ecall_req = 1'b0; ecall_done = 1'b0;
    exp_gnt  = '{3'b001, 3'b010, 3'b100, 3'b001};
    exp_rd   = '{5'd1, 5'd2, 5'd3, 5'd1};
    exp_data = '{64'h11, 64'h22, 64'h33, 64'h11};

    // Reset state
    step(); step();
    chk("rst_we", write_enable, 0);
    chk("rst_wr", write_register, 0);
    chk("rst_wv", write_value, 0);
    chk("rst_ecall", ecall, 0);
    chk("rst_ack", ecall_ack, 0);
    reset = 1'b0;
    settle();
    chk("rst_issue_ready", issue_ready, 1);
    chk("rst_hazard", hazard, 0);

    // 1. Issue x5, hazard, writeback, forward, clear
    issue_valid = 1'b1; issue_rd = 5'd5; settle();
    chk("t1_issue_ready", issue_ready, 1);
    step(); issue_valid = 1'b0; chk_rs1 = 5'd5; settle();
    chk("t1_hazard_busy", hazard, 1);
    set_src(0, 1'b1, 5'd5, 64'hAB); settle();
    chk("t1_src_ready", src_ready, 3'b001);
    step(); set_src(0, 1'b0, 5'd0, 64'h0); settle();
    chk("t1_we", write_enable, 1);
    chk("t1_wr", write_register, 5);
    chk("t1_wv", write_value, 64'hAB);
    chk("t1_hazard_fwd", hazard, 0);
    step();
    chk("t1_we_off", write_enable, 0);
    chk("t1_hazard_clear", hazard, 0);
    chk_rs1 = '0;

    // 2. Round-robin from reset with all producers active
    reset = 1'b1; step(); reset = 1'b0;
    set_src(0, 1'b1, 5'd1, 64'h11);
    set_src(1, 1'b1, 5'd2, 64'h22);
    set_src(2, 1'b1, 5'd3, 64'h33);
    for (int n = 0; n < 4; n++) begin
      settle();
      chk($sformatf("t2_gnt%0d", n), src_ready, exp_gnt[n]);
      step();
      chk($sformatf("t2_we%0d", n), write_enable, 1);
      chk($sformatf("t2_wr%0d", n), write_register, exp_rd[n]);
      chk($sformatf("t2_wv%0d", n), write_value, exp_data[n]);
    end
    src_valid = '0;
    step();
    chk("t2_we_idle", write_enable, 0);

    // 3. WAW stall, and release when the register retires this cycle
    issue_valid = 1'b1; issue_rd = 5'd7; step();
    set_src(1, 1'b1, 5'd7, 64'h77); settle();
    chk("t3_waw_stall", issue_ready, 0);
    chk("t3_gnt1", src_ready, 3'b010);
    step(); set_src(1, 1'b0, 5'd0, 64'h0); settle();
    chk("t3_retire_wr", write_register, 7);
    chk("t3_retire_ready", issue_ready, 1);
    step(); issue_valid = 1'b0; chk_rs1 = 5'd7; settle();
    chk("t3_busy_kept", hazard, 1);
    set_src(2, 1'b1, 5'd7, 64'h78); settle();
    chk("t3_gnt2", src_ready, 3'b100);
    step(); set_src(2, 1'b0, 5'd0, 64'h0); settle();
    chk("t3_wv", write_value, 64'h78);
    step();
    chk("t3_busy_cleared", hazard, 0);

    // 4. x0 handling
    set_src(0, 1'b1, 5'd0, 64'hFF); settle();
    chk("t4_x0_ready", src_ready, 3'b001);
    step(); set_src(0, 1'b0, 5'd0, 64'h0); settle();
    chk("t4_x0_no_we", write_enable, 0);
    issue_valid = 1'b1; issue_rd = 5'd0; settle();
    chk("t4_x0_issue_ready", issue_ready, 1);
    step(); issue_valid = 1'b0; chk_rs1 = 5'd0; chk_rs2 = 5'd0; settle();
    chk("t4_x0_hazard", hazard, 0);

    // 5. Ecall: drain pending x3, call, done after 2 cycles, ack, idle
    issue_valid = 1'b1; issue_rd = 5'd3; step(); issue_valid = 1'b0;
    ecall_req = 1'b1; step();
    issue_valid = 1'b1; issue_rd = 5'd10; settle();
    chk("t5_drain_blocks_issue", issue_ready, 0);
    issue_valid = 1'b0;
    set_src(0, 1'b1, 5'd3, 64'h33); settle();
    chk("t5_drain_grants", src_ready, 3'b001);
    step(); set_src(0, 1'b0, 5'd0, 64'h0); settle();
    chk("t5_drain_we", write_enable, 1);
    chk("t5_ecall_wait1", ecall, 0);
    step();
    chk("t5_ecall_wait2", ecall, 0);
    step();
    chk("t5_ecall_on", ecall, 1);
    set_src(1, 1'b1, 5'd4, 64'h44); settle();
    chk("t5_call_no_grant", src_ready, 3'b000);
    chk("t5_call_no_issue", issue_ready, 0);
    set_src(1, 1'b0, 5'd0, 64'h0);
    step(); step();
    chk("t5_ecall_held", ecall, 1);
    chk("t5_ack_low", ecall_ack, 0);
    ecall_done = 1'b1; step();
    chk("t5_ecall_off", ecall, 0);
    chk("t5_ack_pulse", ecall_ack, 1);
    ecall_done = 1'b0; ecall_req = 1'b0; step();
    chk("t5_ack_one_cycle", ecall_ack, 0);
    chk("t5_idle_issue_ready", issue_ready, 1);

    // 6. Drain abort, reset in drain, reset in call
    issue_valid = 1'b1; issue_rd = 5'd9; step(); issue_valid = 1'b0;
    ecall_req = 1'b1; step(); step();
    chk("t6_drain_stuck", ecall, 0);
    issue_rd = 5'd12; settle();
    chk("t6_drain_issue_blocked", issue_ready, 0);
    ecall_req = 1'b0; step();
    chk("t6_abort_no_ack", ecall_ack, 0);
    chk("t6_abort_idle", issue_ready, 1);
    chk_rs1 = 5'd9; settle();
    chk("t6_x9_busy", hazard, 1);
    ecall_req = 1'b1; step();
    reset = 1'b1; ecall_req = 1'b0; step(); reset = 1'b0; settle();
    chk("t6_rst_drain_ecall", ecall, 0);
    chk("t6_rst_busy_clear", hazard, 0);
    chk("t6_rst_drain_ready", issue_ready, 1);
    ecall_req = 1'b1; step(); step();
    chk("t6_call_reached", ecall, 1);
    reset = 1'b1; ecall_req = 1'b0; step(); reset = 1'b0;
    chk("t6_rst_call_ecall", ecall, 0);
    chk("t6_rst_call_ack", ecall_ack, 0);
    chk("t6_rst_call_we", write_enable, 0);
    set_src(0, 1'b1, 5'd1, 64'h1);
    set_src(1, 1'b1, 5'd2, 64'h2);
    set_src(2, 1'b1, 5'd3, 64'h3);
    settle();
    chk("t6_rr_ptr_zero", src_ready, 3'b001);
    step(); src_valid = '0;
    chk("t6_first_wr", write_register, 1);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
